// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared ALU encodings, forwarding selects, EX register layout and hit helper
package id_ex_stage_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;
  localparam logic [1:0] FWD_REG   = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [3:0]  aluop;
    logic        alusrc;
    logic        shift;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
  } ex_reg_t;
  function automatic logic reg_hit(input logic we, input logic [4:0] rd, input logic [4:0] src);
    return we && rd != 5'd0 && rd == src;
  endfunction
endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: decoded ID bundle in, EX operand/control bundle out
interface id_ex_stage_if;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic        id_use_rs;
  logic        id_use_rt;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [31:0] id_imm;
  logic [4:0]  id_shamt;
  logic [3:0]  id_aluop;
  logic        id_alusrc;
  logic        id_shift;
  logic        id_regwrite;
  logic        id_memread;
  logic        id_memwrite;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic [3:0]  ex_aluop;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_regwrite;
  logic        ex_memread;
  logic        ex_memwrite;
  modport master (
    output id_valid, id_pc, id_rs, id_rt, id_rd, id_use_rs, id_use_rt, id_rs_data, id_rt_data,
           id_imm, id_shamt, id_aluop, id_alusrc, id_shift, id_regwrite, id_memread, id_memwrite,
    input  ex_valid, ex_pc, ex_a, ex_b, ex_aluop, ex_store_data, ex_rd, ex_regwrite, ex_memread, ex_memwrite
  );
  modport slave (
    input  id_valid, id_pc, id_rs, id_rt, id_rd, id_use_rs, id_use_rt, id_rs_data, id_rt_data,
           id_imm, id_shamt, id_aluop, id_alusrc, id_shift, id_regwrite, id_memread, id_memwrite,
    output ex_valid, ex_pc, ex_a, ex_b, ex_aluop, ex_store_data, ex_rd, ex_regwrite, ex_memread, ex_memwrite
  );
endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// fwd_mux: operand select for one source register; bypass paths exist only with EX_FORWARD_EN
module fwd_mux
  import id_ex_stage_pkg::*;
(
  input  logic [4:0]  src,
  input  logic [31:0] reg_data,
  input  logic        exmem_regwrite,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_result,
  input  logic        memwb_regwrite,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_result,
  output logic [1:0]  sel,
  output logic [31:0] value
);
`ifdef EX_FORWARD_EN
  // EX/MEM holds the younger result, so it outranks MEM/WB
  always_comb sel = reg_hit(exmem_regwrite, exmem_rd, src) ? FWD_EXMEM :
                    reg_hit(memwb_regwrite, memwb_rd, src) ? FWD_MEMWB : FWD_REG;
`else
  logic unused;
  assign unused = ^{src, exmem_regwrite, exmem_rd, memwb_regwrite, memwb_rd};
  assign sel = FWD_REG;
`endif
  // value follows the select
  always_comb value = sel == FWD_EXMEM ? exmem_result :
                      sel == FWD_MEMWB ? memwb_result : reg_data;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX register with operand forwarding and hazard stall (EX_FORWARD_EN enables bypass)
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  id_ex_stage_if.slave bus,
  input  logic        stall,
  input  logic        flush,
  input  logic        exmem_regwrite,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_result,
  input  logic        memwb_regwrite,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_result,
  output logic        hazard_stall
);
  ex_reg_t r, nxt;
  logic [1:0] rs_sel, rt_sel;
  logic [31:0] rs_val, rt_val;
  logic unused_sel;
  assign unused_sel = ^{rs_sel, rt_sel};
  // gather the ID bundle into the register layout
  always_comb nxt = '{valid: bus.id_valid, pc: bus.id_pc, rs: bus.id_rs, rt: bus.id_rt, rd: bus.id_rd,
                      rs_data: bus.id_rs_data, rt_data: bus.id_rt_data, imm: bus.id_imm,
                      shamt: bus.id_shamt, aluop: bus.id_aluop, alusrc: bus.id_alusrc,
                      shift: bus.id_shift, regwrite: bus.id_regwrite, memread: bus.id_memread,
                      memwrite: bus.id_memwrite};
  // flush beats stall; a hazard bubble only lands when nothing holds the stage
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r <= '0;
    else if (flush || (!stall && hazard_stall)) r <= '0;
    else if (!stall) r <= nxt;
`ifdef EX_FORWARD_EN
  // only a load in EX cannot be bypassed in time
  always_comb hazard_stall = bus.id_valid &&
    ((bus.id_use_rs && reg_hit(r.valid && r.memread, r.rd, bus.id_rs)) ||
     (bus.id_use_rt && reg_hit(r.valid && r.memread, r.rd, bus.id_rt)));
`else
  // without bypass, wait until the producer reaches write-back
  always_comb hazard_stall = bus.id_valid &&
    ((bus.id_use_rs && (reg_hit(r.valid && r.regwrite, r.rd, bus.id_rs) ||
                        reg_hit(exmem_regwrite, exmem_rd, bus.id_rs))) ||
     (bus.id_use_rt && (reg_hit(r.valid && r.regwrite, r.rd, bus.id_rt) ||
                        reg_hit(exmem_regwrite, exmem_rd, bus.id_rt))));
`endif
  fwd_mux u_fwd_rs (
    .src(r.rs), .reg_data(r.rs_data),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .sel(rs_sel), .value(rs_val)
  );
  fwd_mux u_fwd_rt (
    .src(r.rt), .reg_data(r.rt_data),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .sel(rt_sel), .value(rt_val)
  );
  // ALU operands, store data and valid-gated control
  always_comb begin
    bus.ex_valid      = r.valid;
    bus.ex_pc         = r.pc;
    bus.ex_a          = r.shift ? {27'b0, r.shamt} : rs_val;
    bus.ex_b          = r.alusrc ? r.imm : rt_val;
    bus.ex_aluop      = r.aluop;
    bus.ex_store_data = rt_val;
    bus.ex_rd         = r.rd;
    bus.ex_regwrite   = r.valid && r.regwrite;
    bus.ex_memread    = r.valid && r.memread;
    bus.ex_memwrite   = r.valid && r.memwrite;
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of load, hold, bubble, forwarding and hazard behaviour
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;
  logic clk = 1'b0;
  logic rstn, stall, flush;
  logic exmem_regwrite, memwb_regwrite;
  logic [4:0] exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic hazard_stall;
  int checks = 0;
  int failures = 0;
`ifdef EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  id_ex_stage_if bus ();
  id_ex_stage dut (
    .clk(clk), .rstn(rstn), .bus(bus), .stall(stall), .flush(flush),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .hazard_stall(hazard_stall)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic urs, input logic urt, input logic [31:0] rsd,
                        input logic [31:0] rtd, input logic [3:0] op, input logic rw, input logic mr);
    bus.id_valid = v; bus.id_pc = pc; bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
    bus.id_use_rs = urs; bus.id_use_rt = urt; bus.id_rs_data = rsd; bus.id_rt_data = rtd;
    bus.id_aluop = op; bus.id_regwrite = rw; bus.id_memread = mr; bus.id_memwrite = 1'b0;
    bus.id_imm = '0; bus.id_shamt = '0; bus.id_alusrc = 1'b0; bus.id_shift = 1'b0;
    #1;
  endtask
  initial begin
    rstn = 1'b0; stall = 1'b0; flush = 1'b0;
    exmem_regwrite = 1'b0; exmem_rd = '0; exmem_result = '0;
    memwb_regwrite = 1'b0; memwb_rd = '0; memwb_result = '0;
    set_id(1, 32'h40, 1, 2, 3, 1, 1, 32'h5, 32'h7, ALU_SUB, 1, 0);
    tick();
    chk("rst_valid", bus.ex_valid, 0);
    chk("rst_regwrite", bus.ex_regwrite, 0);
    chk("rst_aluop", bus.ex_aluop, 0);
    chk("rst_pc", bus.ex_pc, 0);
    chk("rst_a", bus.ex_a, 0);
    chk("rst_hz", hazard_stall, 0);
    rstn = 1'b1;
    set_id(1, 32'h100, 1, 2, 3, 1, 1, 32'h5, 32'h7, ALU_ADD, 1, 0);
    tick();
    chk("add_a", bus.ex_a, 32'h5);
    chk("add_b", bus.ex_b, 32'h7);
    chk("add_valid", bus.ex_valid, 1);
    chk("add_pc", bus.ex_pc, 32'h100);
    chk("add_rd", bus.ex_rd, 3);
    chk("add_rw", bus.ex_regwrite, 1);
    stall = 1'b1;
    set_id(1, 32'h200, 7, 8, 6, 1, 1, 32'h9, 32'h8, ALU_SUB, 0, 1);
    repeat (3) tick();
    chk("stall_pc", bus.ex_pc, 32'h100);
    chk("stall_a", bus.ex_a, 32'h5);
    chk("stall_b", bus.ex_b, 32'h7);
    chk("stall_rd", bus.ex_rd, 3);
    chk("stall_op", bus.ex_aluop, ALU_ADD);
    chk("stall_mr", bus.ex_memread, 0);
    flush = 1'b1;
    tick();
    chk("flush_valid", bus.ex_valid, 0);
    chk("flush_rw", bus.ex_regwrite, 0);
    chk("flush_pc", bus.ex_pc, 0);
    flush = 1'b0; stall = 1'b0;
    set_id(1, 32'h300, 0, 2, 10, 0, 1, 32'hdead, 32'h55, ALU_SLL, 1, 0);
    bus.id_shift = 1'b1; bus.id_shamt = 5'd4;
    tick();
    chk("sll_a", bus.ex_a, 32'h4);
    chk("sll_b", bus.ex_b, 32'h55);
    chk("sll_op", bus.ex_aluop, ALU_SLL);
    set_id(1, 32'h304, 0, 9, 9, 0, 0, 32'h0, 32'h77, ALU_LUI, 1, 0);
    bus.id_alusrc = 1'b1; bus.id_imm = 32'h1234;
    tick();
    exmem_regwrite = 1'b1; exmem_rd = 5'd9; exmem_result = 32'habc;
    #1;
    chk("lui_b", bus.ex_b, 32'h1234);
    chk("lui_sd", bus.ex_store_data, FWD ? 32'habc : 32'h77);
    exmem_regwrite = 1'b0;
    set_id(1, 32'h308, 3, 0, 11, 1, 0, 32'h33, 32'h0, ALU_ADD, 1, 0);
    tick();
    exmem_regwrite = 1'b1; exmem_rd = 5'd3; exmem_result = 32'h11;
    memwb_regwrite = 1'b1; memwb_rd = 5'd3; memwb_result = 32'h22;
    #1;
    chk("prio_exmem", bus.ex_a, FWD ? 32'h11 : 32'h33);
    exmem_regwrite = 1'b0;
    #1;
    chk("prio_memwb", bus.ex_a, FWD ? 32'h22 : 32'h33);
    memwb_regwrite = 1'b0;
    set_id(1, 32'h30c, 0, 0, 12, 1, 0, 32'h44, 32'h0, ALU_ADD, 1, 0);
    tick();
    exmem_regwrite = 1'b1; exmem_rd = 5'd0; memwb_regwrite = 1'b1; memwb_rd = 5'd0;
    #1;
    chk("r0_nofwd", bus.ex_a, 32'h44);
    exmem_regwrite = 1'b0; memwb_regwrite = 1'b0;
    set_id(1, 32'h310, 0, 0, 0, 1, 0, 32'h0, 32'h0, ALU_ADD, 1, 1);
    tick();
    set_id(1, 32'h314, 0, 0, 13, 1, 1, 32'h0, 32'h0, ALU_ADD, 1, 0);
    chk("r0_nohz", hazard_stall, 0);
    tick();
    set_id(1, 32'h318, 1, 0, 4, 1, 0, 32'h0, 32'h0, ALU_ADD, 1, 1);
    tick();
    chk("lw_mr", bus.ex_memread, 1);
    set_id(0, 32'h31c, 4, 0, 14, 1, 0, 32'h99, 32'h0, ALU_ADD, 1, 0);
    chk("lu_inv_hz", hazard_stall, 0);
    bus.id_valid = 1'b1;
    #1;
    chk("lu_hz", hazard_stall, 1);
    tick();
    chk("lu_bubble", bus.ex_valid, 0);
    chk("lu_bub_rw", bus.ex_regwrite, 0);
    exmem_regwrite = 1'b1; exmem_rd = 5'd4; exmem_result = 32'h1000;
    #1;
    chk("lu_hz2", hazard_stall, FWD ? 0 : 1);
    tick();
    if (FWD) begin
      exmem_regwrite = 1'b0; memwb_regwrite = 1'b1; memwb_rd = 5'd4; memwb_result = 32'h4444;
      #1;
      chk("lu_valid", bus.ex_valid, 1);
      chk("lu_a", bus.ex_a, 32'h4444);
    end else begin
      chk("lu_bubble2", bus.ex_valid, 0);
      exmem_regwrite = 1'b0; memwb_regwrite = 1'b1; memwb_rd = 5'd4; memwb_result = 32'h4444;
      #1;
      chk("lu_hz3", hazard_stall, 0);
      tick();
      memwb_regwrite = 1'b0;
      #1;
      chk("lu_valid", bus.ex_valid, 1);
      chk("lu_a", bus.ex_a, 32'h99);
    end
    memwb_regwrite = 1'b0;
    set_id(1, 32'h320, 0, 0, 5, 0, 0, 32'h0, 32'h0, ALU_ADD, 1, 0);
    tick();
    set_id(1, 32'h324, 0, 5, 15, 0, 1, 32'h0, 32'h55, ALU_ADD, 1, 0);
    chk("raw_hz", hazard_stall, FWD ? 0 : 1);
    tick();
    if (FWD) begin
      exmem_regwrite = 1'b1; exmem_rd = 5'd5; exmem_result = 32'h5a5a;
      #1;
      chk("raw_valid", bus.ex_valid, 1);
      chk("raw_b", bus.ex_b, 32'h5a5a);
    end else begin
      chk("raw_bubble", bus.ex_valid, 0);
      exmem_regwrite = 1'b1; exmem_rd = 5'd5; exmem_result = 32'h5a5a;
      #1;
      chk("raw_hz2", hazard_stall, 1);
      tick();
      chk("raw_bubble2", bus.ex_valid, 0);
      exmem_regwrite = 1'b0; memwb_regwrite = 1'b1; memwb_rd = 5'd5; memwb_result = 32'hbeef;
      #1;
      chk("raw_hz3", hazard_stall, 0);
      tick();
      memwb_regwrite = 1'b0;
      #1;
      chk("raw_valid", bus.ex_valid, 1);
      chk("raw_b", bus.ex_b, 32'h55);
    end
    exmem_regwrite = 1'b0; memwb_regwrite = 1'b0;
    chk("raw_pc", bus.ex_pc, 32'h324);
    stall = 1'b1;
    #3;
    rstn = 1'b0;
    #1;
    chk("rst_stall_valid", bus.ex_valid, 0);
    chk("rst_stall_pc", bus.ex_pc, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with EX-stage operand forwarding and load-use hazard detection. It captures decoded instruction state at the ID→EX boundary. It resolves RAW dependencies against the EX/MEM and MEM/WB stages and drives the ALU's A, B and ALUOp inputs directly. It also supplies store data and destination/control fields to the EX/MEM register.

## Interface
- No parameters. Widths are fixed: data 32, register index 5, ALUOp 4.
- clk  in  1  rising-edge clock
- rstn  in  1  asynchronous reset, active low
- id_valid  in  1  ID stage holds a real instruction
- id_pc  in  32  PC of the ID instruction
- id_rs, id_rt, id_rd  in  5 each  source registers and destination register
- id_use_rs, id_use_rt  in  1 each  instruction actually reads rs / rt
- id_rs_data, id_rt_data  in  32 each  register-file read data
- id_imm  in  32  already sign- or zero-extended immediate
- id_shamt  in  5  shift amount
- id_aluop  in  4  ALU operation code, shared ALU encoding
- id_alusrc  in  1  B operand comes from id_imm
- id_shift  in  1  A operand comes from {27'b0, shamt}
- id_regwrite, id_memread, id_memwrite  in  1 each  control bits
- stall  in  1  external hold (e.g. memory wait)
- flush  in  1  squash (branch/jump resolved)
- exmem_regwrite  in  1; exmem_rd  in  5; exmem_result  in  32  EX/MEM forwarding source
- memwb_regwrite  in  1; memwb_rd  in  5; memwb_result  in  32  MEM/WB forwarding source
- ex_valid  out  1  EX-stage instruction valid
- ex_pc  out  32
- ex_a, ex_b  out  32 each  ALU operands
- ex_aluop  out  4
- ex_store_data  out  32  forwarded rt value
- ex_rd  out  5
- ex_regwrite, ex_memread, ex_memwrite  out  1 each  gated by ex_valid
- hazard_stall  out  1  upstream must hold PC and IF/ID this cycle

## Operation
- Register update priority per clock edge: flush > stall > hazard_stall > load.
  - flush: ex_valid←0 and all control bits←0. Data fields are don't-care but zeroed.
  - stall (no flush): every field holds.
  - hazard_stall (no flush, no stall): insert a bubble, same as flush.
  - Otherwise: load all id_* fields, with ex_valid←id_valid.
- Control outputs are ANDed with the registered valid bit. A bubble never writes a register or touches memory.
- Forwarding, per source (rs, rt), combinational from registered fields:
  - If exmem_regwrite, exmem_rd≠0 and exmem_rd==src: use exmem_result.
  - Else if memwb_regwrite, memwb_rd≠0 and memwb_rd==src: use memwb_result.
  - Else use the registered register-file data.
  - EX/MEM always wins over MEM/WB.
- ex_a = registered shift ? {27'b0, shamt} : fwd_rs.
- ex_b = registered alusrc ? imm : fwd_rt.
- ex_store_data = fwd_rt, regardless of alusrc.
- hazard_stall (load-use) = id_valid & ex_valid & ex_memread & ex_rd≠0 & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)).
- Register $0 is never a hazard or forwarding match.

## Timing
- Latency: one cycle. id_* sampled at edge N appear on ex_* during cycle N+1.
- ex_a, ex_b and ex_store_data are combinational from registers and the exmem_/memwb_ inputs, within the same cycle.
- hazard_stall is combinational and asserted in the same cycle as the conflicting ID instruction. It produces exactly one bubble for a load-use pair, after which MEM/WB forwarding resolves the dependency.
- Reset (rstn low, asynchronous): every register clears to 0.
  - ex_valid=0, ex_pc=0, ex_aluop=0, ex_rd=0, all control outputs 0, hazard_stall=0.
  - ex_a, ex_b and ex_store_data = 0, unless a forwarding input matches a nonzero register.
- Reset mid-stall discards the held instruction.
- stall together with hazard_stall: hold, no bubble; hazard_stall stays asserted.

## Configuration
- EX_FORWARD_EN defined: forwarding as described above. hazard_stall covers load-use only.
- EX_FORWARD_EN undefined: no forwarding paths.
  - Operands come only from the registered register-file data.
  - hazard_stall asserts when any used ID source matches a nonzero destination with regwrite set in either:
    - the EX stage (ex_valid & ex_regwrite), or
    - the EX/MEM stage (exmem_regwrite).
  - The register file returns the MEM/WB write value in the same cycle, so MEM/WB needs no stall.

## Structure
- Shared package/header holds:
  - ALU op encodings (existing shared ALU encoding header).
  - Forwarding select constants FWD_REG, FWD_EXMEM, FWD_MEMWB (2-bit).
- One sub-module, fwd_mux: computes the select and 32-bit value for one source register. It is instantiated twice, for rs and rt.

## Test plan
- Reset: hold rstn low with id_valid=1 and id_regwrite=1 → ex_valid=0, ex_regwrite=0, ex_aluop=0.
  - After release and one edge with ADD, id_rs_data=5, id_rt_data=7 → ex_a=5, ex_b=7.
- Forward priority: registered rs=3; exmem_rd=3 result 0x11; memwb_rd=3 result 0x22 → ex_a=0x11.
  - Drop exmem_regwrite → ex_a=0x22.
  - Set rs=0 → ex_a = register data.
- Load-use: lw $4 in EX, ID instruction add with rs=4 and id_use_rs=1 → hazard_stall=1 for one cycle.
  - Next edge: ex_valid=0.
  - Following cycle: add enters EX and ex_a takes memwb_result.
- Flush and stall together: stall=1, flush=1 → ex_valid=0 next cycle.
  - stall=1 alone → all ex_* fields unchanged across 3 edges.
- Shift/immediate: SLL with shamt=4, id_shift=1 → ex_a=4.
  - LUI with id_alusrc=1, imm=0x1234 → ex_b=0x1234 while ex_store_data = forwarded rt.
- EX_FORWARD_EN undefined: add rd=5 in EX, ID instruction reads rt=5 → hazard_stall=1 for 2 cycles, then the instruction proceeds with register data.
